// File: rtl/compare_sweep.sv
// compare_sweep
//   Stimulus driver and checker for a 4-bit magnitude comparator. It walks all
//   256 {input1,input2} operand pairs in unsigned or signed mode. Each pair is
//   held for TICK_DIV cycles and then sampled for one cycle. The comparator's
//   one-hot result is checked against an internal golden compare, and
//   eq/gt/lt/error tallies are kept.
//
// Ports
//   MAX10_CLK1_50  in   system clock, rising edge
//   RST            in   synchronous active-high reset
//   start          in   one-cycle pulse, begins a sweep from IDLE or DONE
//   mode           in   0 = unsigned, 1 = signed compare (latched on start)
//   result         in   comparator result: 100 eq, 010 A>B, 001 A<B
//   input1/input2  out  operands A/B driven to the comparator
//   scomp          out  comparator mode {1'b1, latched mode}
//   busy           out  sweep in progress
//   done           out  sweep finished, held until start or RST
//   eq/gt/lt_cnt   out  pairs the comparator reported equal / greater / less
//   err_cnt        out  pairs whose result disagreed with the golden compare
//   first_err      out  {input1,input2} of the first failing pair
module compare_sweep #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RST,
  input  logic       start,
  input  logic       mode,
  input  logic [2:0] result,
  output logic [3:0] input1,
  output logic [3:0] input2,
  output logic [1:0] scomp,
  output logic       busy,
  output logic       done,
  output logic [8:0] eq_cnt,
  output logic [8:0] gt_cnt,
  output logic [8:0] lt_cnt,
  output logic [8:0] err_cnt,
  output logic [7:0] first_err
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_mode;
  logic [7:0]       r_pair;
  logic [CNT_W-1:0] r_settle;
  logic [8:0]       r_eq;
  logic [8:0]       r_gt;
  logic [8:0]       r_lt;
  logic [8:0]       r_err;
  logic [7:0]       r_first_err;

  logic             w_launch;
  logic             w_last;
  logic [2:0]       w_golden;
  logic             w_mismatch;

  // Golden compare. The operands are widened to 5 bits so that a single signed
  // comparison handles both modes: zero-extend for unsigned, sign-extend for signed.
  function automatic logic [2:0] golden_cmp(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic       is_signed);
    logic signed [4:0] sa;
    logic signed [4:0] sb;
    sa = is_signed ? {a[3], a} : {1'b0, a};
    sb = is_signed ? {b[3], b} : {1'b0, b};
    if (sa == sb)     return 3'b100;
    else if (sa > sb) return 3'b010;
    else              return 3'b001;
  endfunction

  assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_pair == 8'hFF);
  assign w_golden   = golden_cmp(r_pair[7:4], r_pair[3:0], r_mode);
  assign w_mismatch = (result != w_golden);

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)            w_next = S_SETTLE;
      S_SETTLE:       if (r_settle == '0)   w_next = S_CHECK;
      S_CHECK:        w_next = w_last ? S_DONE : S_SETTLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      r_mode      <= 1'b0;
      r_pair      <= 8'h00;
      r_settle    <= '0;
      r_eq        <= 9'd0;
      r_gt        <= 9'd0;
      r_lt        <= 9'd0;
      r_err       <= 9'd0;
      r_first_err <= 8'h00;
    end else if (w_launch) begin
      r_mode      <= mode;
      r_pair      <= 8'h00;
      r_settle    <= SETTLE_RELOAD;
      r_eq        <= 9'd0;
      r_gt        <= 9'd0;
      r_lt        <= 9'd0;
      r_err       <= 9'd0;
      r_first_err <= 8'h00;
    end else if (r_state == S_SETTLE) begin
      if (r_settle != '0) r_settle <= r_settle - 1'b1;
    end else if (r_state == S_CHECK) begin
      case (result)
        3'b100:  r_eq <= r_eq + 9'd1;
        3'b010:  r_gt <= r_gt + 9'd1;
        3'b001:  r_lt <= r_lt + 9'd1;
        default: ;
      endcase
      if (w_mismatch) begin
        r_err <= r_err + 9'd1;
        if (r_err == 9'd0) r_first_err <= r_pair;
      end
      // A single 8-bit increment steps input2 and carries into input1 on F->0.
      if (!w_last) begin
        r_pair   <= r_pair + 8'd1;
        r_settle <= SETTLE_RELOAD;
      end
    end
  end

  assign input1    = r_pair[7:4];
  assign input2    = r_pair[3:0];
  assign scomp     = {1'b1, r_mode};
  assign busy      = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign eq_cnt    = r_eq;
  assign gt_cnt    = r_gt;
  assign lt_cnt    = r_lt;
  assign err_cnt   = r_err;
  assign first_err = r_first_err;

endmodule

// File: tb/tb_compare_sweep.sv
// tb_compare_sweep
//   Drives two compare_sweep instances (TICK_DIV=1 and TICK_DIV=4), each wired to a
//   behavioural 4-bit comparator that can inject faults. Every sweep start pushes
//   its hand-computed final tallies and completion cycle into a queue. A monitor
//   pops and compares each entry when done rises.
`timescale 1ns/1ps
module tb_compare_sweep;

  typedef struct {
    logic [8:0] eq;
    logic [8:0] gt;
    logic [8:0] lt;
    logic [8:0] err;
    logic [7:0] fe;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic start1 = 1'b0;
  logic start4 = 1'b0;
  int   fault1 = 0;
  int   fault4 = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [3:0] a1, b1, a4, b4;
  logic [1:0] sc1, sc4;
  logic       busy1, done1, busy4, done4;
  logic [8:0] eq1, gt1, lt1, er1, eq4, gt4, lt4, er4;
  logic [7:0] fe1, fe4;
  logic [2:0] res1, res4;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  logic prev_done1 = 1'b0;
  logic prev_done4 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model. f: 0 ideal, 1 reports 010 for A=3,B=3, 2 always 000,
  // 3 ignores signed mode (always unsigned).
  function automatic logic [2:0] cmp_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic sgn, input int f);
    int ia, ib;
    if (f == 2) return 3'b000;
    if (f == 1 && a == 4'd3 && b == 4'd3) return 3'b010;
    ia = int'(a);
    ib = int'(b);
    if (sgn && f != 3) begin
      if (ia >= 8) ia = ia - 16;
      if (ib >= 8) ib = ib - 16;
    end
    if (ia == ib)     return 3'b100;
    else if (ia > ib) return 3'b010;
    else              return 3'b001;
  endfunction

  assign res1 = cmp_model(a1, b1, sc1[0], fault1);
  assign res4 = cmp_model(a4, b4, sc4[0], fault4);

  compare_sweep #(.TICK_DIV(1)) u_dut1 (
    .MAX10_CLK1_50(clk), .RST(rst), .start(start1), .mode(mode), .result(res1),
    .input1(a1), .input2(b1), .scomp(sc1), .busy(busy1), .done(done1),
    .eq_cnt(eq1), .gt_cnt(gt1), .lt_cnt(lt1), .err_cnt(er1), .first_err(fe1)
  );

  compare_sweep #(.TICK_DIV(4)) u_dut4 (
    .MAX10_CLK1_50(clk), .RST(rst), .start(start4), .mode(mode), .result(res4),
    .input1(a4), .input2(b4), .scomp(sc4), .busy(busy4), .done(done4),
    .eq_cnt(eq4), .gt_cnt(gt4), .lt_cnt(lt4), .err_cnt(er4), .first_err(fe4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: compares the final tallies and completion cycle when done rises.
  always @(negedge clk) begin
    if (done1 && !prev_done1) begin
      if (q1.size() == 0) chk("sb1_unexpected_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("sb1_eq", eq1, e1.eq);
        chk("sb1_gt", gt1, e1.gt);
        chk("sb1_lt", lt1, e1.lt);
        chk("sb1_err", er1, e1.err);
        chk("sb1_first_err", fe1, e1.fe);
        chk("sb1_done_cycle", cyc, e1.cyc);
      end
    end
    if (done4 && !prev_done4) begin
      if (q4.size() == 0) chk("sb4_unexpected_done", 1, 0);
      else begin
        e4 = q4.pop_front();
        chk("sb4_eq", eq4, e4.eq);
        chk("sb4_gt", gt4, e4.gt);
        chk("sb4_lt", lt4, e4.lt);
        chk("sb4_err", er4, e4.err);
        chk("sb4_first_err", fe4, e4.fe);
        chk("sb4_done_cycle", cyc, e4.cyc);
      end
    end
    prev_done1 = done1;
    prev_done4 = done4;
  end

  // Called at a negedge. Returns one negedge after the start edge.
  task automatic start_sweep(input int which, input logic m, input logic [8:0] eq,
                             input logic [8:0] gt, input logic [8:0] lt,
                             input logic [8:0] err, input logic [7:0] fe);
    exp_t e;
    int   tdiv;
    tdiv  = (which == 1) ? 1 : 4;
    e.eq  = eq; e.gt = gt; e.lt = lt; e.err = err; e.fe = fe;
    e.cyc = cyc + 256 * (tdiv + 1) + 1;
    if (which == 1) q1.push_back(e); else q4.push_back(e);
    mode = m;
    if (which == 1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, output int scomp_bad);
    int k;
    k = 0;
    scomp_bad = 0;
    while (k < budget) begin
      if ((which == 1) ? done1 : done4) break;
      if (which == 1 && busy1 && sc1 !== 2'b11) scomp_bad++;
      @(negedge clk);
      k++;
    end
    chk("done_reached", (which == 1) ? done1 : done4, 1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_operands", {a1, b1}, 8'h00);
    chk("rst_scomp", sc1, 2'b10);
    chk("rst_busy_done", {busy1, done1}, 2'b00);
    chk("rst_counters", {eq1, gt1, lt1, er1}, 36'd0);
    chk("rst_first_err", fe1, 8'h00);
    chk("rst4_state", {a4, b4, busy4, done4}, 10'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ideal unsigned sweep
    fault1 = 0;
    start_sweep(1, 1'b0, 9'd16, 9'd120, 9'd120, 9'd0, 8'h00);
    chk("sweep_busy_after_start", {busy1, done1}, 2'b10);
    wait_done(1, 600, bad);

    // Ideal signed sweep. The mode toggle mid-sweep has to be ignored.
    start_sweep(1, 1'b1, 9'd16, 9'd120, 9'd120, 9'd0, 8'h00);
    mode = 1'b0;
    wait_done(1, 600, bad);
    chk("signed_scomp_during_sweep", bad, 0);
    chk("signed_scomp_at_done", sc1, 2'b11);
    chk("done_operands_hold", {a1, b1}, 8'hFF);

    // Comparator lies at A=3,B=3
    fault1 = 1;
    start_sweep(1, 1'b0, 9'd15, 9'd121, 9'd120, 9'd1, 8'h33);
    wait_done(1, 600, bad);

    // Comparator returns 000 for all pairs
    fault1 = 2;
    start_sweep(1, 1'b0, 9'd0, 9'd0, 9'd0, 9'd256, 8'h00);
    wait_done(1, 600, bad);

    // Signed sweep against an unsigned comparator: the 128 pairs whose operands
    // differ in sign bit disagree, and the first of them is A=0,B=8.
    fault1 = 3;
    start_sweep(1, 1'b1, 9'd16, 9'd120, 9'd120, 9'd128, 8'h08);
    wait_done(1, 600, bad);

    // A start while busy is ignored, then RST is applied mid-sweep
    fault1 = 0;
    mode = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("ignored_start_pair", {a1, b1}, 8'h03);
    chk("ignored_start_busy", busy1, 1);
    repeat (174) @(negedge clk);            // 2 cycles per pair: 0x5A pairs after start
    chk("pre_rst_pair", {a1, b1}, 8'h5A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_operands", {a1, b1}, 8'h00);
    chk("midrst_busy_done", {busy1, done1}, 2'b00);
    chk("midrst_counters", {eq1, gt1, lt1, er1}, 36'd0);
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", {busy1, a1, b1}, 9'd0);

    // TICK_DIV=4: 5 cycles per pair, then a restart from DONE
    fault4 = 0;
    start_sweep(4, 1'b0, 9'd16, 9'd120, 9'd120, 9'd0, 8'h00);
    repeat (4) @(negedge clk);
    chk("tick4_pair_held", {a4, b4}, 8'h00);
    @(negedge clk);
    chk("tick4_pair_advance", {a4, b4}, 8'h01);
    wait_done(4, 1400, bad);
    repeat (3) @(negedge clk);
    chk("tick4_done_holds", {done4, busy4}, 2'b10);
    chk("tick4_eq_holds", eq4, 9'd16);
    fault4 = 1;
    start_sweep(4, 1'b0, 9'd15, 9'd121, 9'd120, 9'd1, 8'h33);
    chk("restart_cleared", {eq4, gt4, lt4, er4}, 36'd0);
    chk("restart_busy_done", {busy4, done4}, 2'b10);
    wait_done(4, 1400, bad);

    repeat (2) @(negedge clk);
    chk("sb1_queue_drained", q1.size(), 0);
    chk("sb4_queue_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
